// File: rtl/gcd_unit_arbiter.sv
// Shares one GCD unit among p_num_reqs requester streams: round-robin issue,
// with an in-order tag FIFO that steers each result back to its requester.
module gcd_unit_arbiter #(
  parameter int p_num_reqs  = 4,
  parameter int p_tag_depth = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [p_num_reqs*32-1:0]          req_msg,
  input  logic [p_num_reqs-1:0]             req_val,
  output logic [p_num_reqs-1:0]             req_rdy,
  output logic [p_num_reqs*16-1:0]          resp_msg,
  output logic [p_num_reqs-1:0]             resp_val,
  input  logic [p_num_reqs-1:0]             resp_rdy,
  output logic [31:0]                       gcd_req_msg,
  output logic                              gcd_req_val,
  input  logic                              gcd_req_rdy,
  input  logic [15:0]                       gcd_resp_msg,
  input  logic                              gcd_resp_val,
  output logic                              gcd_resp_rdy,
  output logic [$clog2(p_tag_depth+1)-1:0]  inflight
);

  localparam int TW = $clog2(p_num_reqs);
  localparam int AW = $clog2(p_tag_depth);
  localparam int CW = $clog2(p_tag_depth + 1);

  // Handshakes: a transfer happens on a rising edge where val and rdy are both 1;
  // val never depends on rdy of the same stream, and rdy is never raised without val.

  logic [p_num_reqs-1:0] one_hot_lsb;
  logic [TW-1:0]         ptr;
  logic [TW-1:0]         grant;
  logic                  grant_vld;
  logic [TW:0]           scan_sum;
  logic [TW-1:0]         scan_idx;
  logic [TW-1:0]         tag_mem [p_tag_depth];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [TW-1:0]         head;
  logic                  full;
  logic                  empty;
  logic                  issue_fire;
  logic                  resp_fire;

  assign one_hot_lsb = {{(p_num_reqs-1){1'b0}}, 1'b1};
  assign full        = (count == CW'(p_tag_depth));
  assign empty       = (count == '0);

  // Scan lanes starting at ptr, wrapping modulo p_num_reqs (need not be a power of 2).
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < p_num_reqs; k++) begin
      scan_sum = {1'b0, ptr} + (TW+1)'(k);
      if (scan_sum >= (TW+1)'(p_num_reqs)) scan_sum = scan_sum - (TW+1)'(p_num_reqs);
      scan_idx = scan_sum[TW-1:0];
      if (!grant_vld && req_val[scan_idx]) begin
        grant_vld = 1'b1;
        grant     = scan_idx;
      end
    end
  end

  always_comb begin
    gcd_req_msg = '0;
    for (int i = 0; i < p_num_reqs; i++) begin
      if (grant_vld && grant == TW'(i)) gcd_req_msg = req_msg[32*i +: 32];
    end
  end

  // full comes from registered count only, so a same-cycle pop never frees a slot.
  assign issue_fire  = grant_vld & gcd_req_rdy & ~full & ~rst;
  assign gcd_req_val = (|req_val) & ~full & ~rst;
  assign req_rdy     = issue_fire ? (one_hot_lsb << grant) : '0;

  assign head         = tag_mem[rd_ptr];
  assign gcd_resp_rdy = ~empty & resp_rdy[head] & ~rst;
  assign resp_fire    = gcd_resp_val & gcd_resp_rdy;
  assign resp_val     = (gcd_resp_val & ~empty & ~rst) ? (one_hot_lsb << head) : '0;
  assign resp_msg     = {p_num_reqs{gcd_resp_msg}};
  assign inflight     = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (issue_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        ptr    <= (grant == TW'(p_num_reqs - 1)) ? '0 : grant + 1'b1;
      end
      if (resp_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({issue_fire, resp_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (issue_fire) tag_mem[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_gcd_unit_arbiter.sv
// Directed bench for gcd_unit_arbiter with a behavioural multi-entry GCD unit
// on the shared port and a per-lane scoreboard of expected results.
module tb_gcd_unit_arbiter;

  localparam int N = 4;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*32-1:0]          req_msg = '0;
  logic [N-1:0]             req_val = '0;
  logic [N-1:0]             req_rdy;
  logic [N*16-1:0]          resp_msg;
  logic [N-1:0]             resp_val;
  logic [N-1:0]             resp_rdy = '0;
  logic [31:0]              gcd_req_msg;
  logic                     gcd_req_val;
  logic                     gcd_req_rdy = 1'b1;
  logic [15:0]              gcd_resp_msg = '0;
  logic                     gcd_resp_val = 1'b0;
  logic                     gcd_resp_rdy;
  logic [$clog2(D+1)-1:0]   inflight;

  gcd_unit_arbiter #(.p_num_reqs(N), .p_tag_depth(D)) dut (
    .clk(clk), .rst(rst),
    .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy),
    .resp_msg(resp_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .gcd_req_msg(gcd_req_msg), .gcd_req_val(gcd_req_val), .gcd_req_rdy(gcd_req_rdy),
    .gcd_resp_msg(gcd_resp_msg), .gcd_resp_val(gcd_resp_val), .gcd_resp_rdy(gcd_resp_rdy),
    .inflight(inflight)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] gcd16(input logic [31:0] m);
    logic [15:0] a, b, t;
    a = m[31:16];
    b = m[15:0];
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural GCD unit ----------------
  typedef struct packed {
    logic [15:0] res;
    int          ready_at;
  } gcd_ent_t;

  gcd_ent_t    gq[$];
  gcd_ent_t    ent;
  int          cyc = 0;
  logic        g_req_fire = 1'b0;
  logic        g_resp_fire = 1'b0;
  logic [31:0] g_req_msg_s = '0;

  always @(negedge clk) begin
    g_req_fire  = gcd_req_val & gcd_req_rdy;
    g_resp_fire = gcd_resp_val & gcd_resp_rdy;
    g_req_msg_s = gcd_req_msg;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      gq.delete();
      gcd_req_rdy  <= 1'b1;
      gcd_resp_val <= 1'b0;
      gcd_resp_msg <= '0;
    end else begin
      cyc++;
      if (g_resp_fire && gq.size() > 0) void'(gq.pop_front());
      if (g_req_fire) begin
        ent.res      = gcd16(g_req_msg_s);
        ent.ready_at = cyc + int'($urandom_range(1, 4));
        gq.push_back(ent);
      end
      gcd_req_rdy <= (gq.size() < 4);
      if (gq.size() > 0) begin
        gcd_resp_val <= (gq[0].ready_at <= cyc);
        gcd_resp_msg <= gq[0].res;
      end else begin
        gcd_resp_val <= 1'b0;
        gcd_resp_msg <= '0;
      end
    end
  end

  // ---------------- requester / responder drivers ----------------
  logic [31:0] pend_q[N][$];
  int          gap[N];
  int          max_gap = 0;
  logic [N-1:0] fired = '0;
  bit          rdy_random = 1'b0;
  logic [N-1:0] rdy_fixed = '1;

  initial for (int l = 0; l < N; l++) gap[l] = 0;

  always @(posedge clk) begin
    #1;
    for (int l = 0; l < N; l++) begin
      if (fired[l]) begin
        void'(pend_q[l].pop_front());
        req_val[l] = 1'b0;
        gap[l] = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      end
      if (!req_val[l] && pend_q[l].size() > 0) begin
        if (gap[l] > 0) gap[l]--;
        else begin
          req_val[l] = 1'b1;
          req_msg[l*32 +: 32] = pend_q[l][0];
        end
      end
      resp_rdy[l] = rdy_random ? 1'($urandom_range(0, 1)) : rdy_fixed[l];
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [15:0] exp_q[N][$];
  int          issue_log[$];
  int          resp_lane_log[$];
  logic [15:0] resp_msg_log[$];

  always @(negedge clk) begin
    if (rst) begin
      fired = '0;
      for (int l = 0; l < N; l++) exp_q[l].delete();
    end else begin
      for (int l = 0; l < N; l++) begin
        fired[l] = req_val[l] & req_rdy[l];
        if (fired[l]) begin
          exp_q[l].push_back(gcd16(req_msg[l*32 +: 32]));
          issue_log.push_back(l);
        end
        if (resp_val[l] & resp_rdy[l]) begin
          check("resp_has_expected", 32'(exp_q[l].size() > 0), 1);
          if (exp_q[l].size() > 0) check("resp_data", resp_msg[l*16 +: 16], exp_q[l].pop_front());
          resp_lane_log.push_back(l);
          resp_msg_log.push_back(resp_msg[l*16 +: 16]);
        end
      end
      check("resp_val_onehot0", 32'($onehot0(resp_val)), 1);
      check("req_rdy_without_val", 32'(req_rdy & ~req_val), 0);
      if (inflight == D) check("full_blocks_issue", {req_rdy, gcd_req_val}, 0);
    end
  end

  function automatic bit all_idle();
    bit idle;
    idle = (inflight == 0) && (req_val == '0);
    for (int l = 0; l < N; l++)
      if (pend_q[l].size() != 0 || exp_q[l].size() != 0) idle = 1'b0;
    return idle;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = all_idle();
    end
    check(tag, 32'(done), 1);
  endtask

  task automatic check_resp(input string tag, input int idx, input int lane, input logic [15:0] val);
    if (idx < resp_lane_log.size()) begin
      check({tag, "_lane"}, resp_lane_log[idx], lane);
      check({tag, "_data"}, resp_msg_log[idx], val);
    end else check({tag, "_missing"}, resp_lane_log.size(), idx + 1);
  endtask

  task automatic check_issue(input string tag, input int idx, input int lane);
    if (idx < issue_log.size()) check(tag, issue_log[idx], lane);
    else check({tag, "_missing"}, issue_log.size(), idx + 1);
  endtask

  // ---------------- directed sequence ----------------
  int base_r, base_i, n, ln;
  logic [15:0] rr_exp[4];
  logic [15:0] full_exp[6];
  logic [31:0] full_msg[6];

  initial begin
    rr_exp   = '{16'd3, 16'd7, 16'd5, 16'd40};
    full_msg = '{{16'd12, 16'd18}, {16'd100, 16'd75}, {16'd7, 16'd13},
                 {16'd64, 16'd48}, {16'd81, 16'd27}, {16'd0, 16'd9}};
    full_exp = '{16'd6, 16'd25, 16'd1, 16'd16, 16'd27, 16'd9};

    repeat (3) @(negedge clk);
    check("rst_inflight", inflight, 0);
    check("rst_req_rdy", req_rdy, 0);
    check("rst_resp_val", resp_val, 0);
    check("rst_gcd_req_val", gcd_req_val, 0);
    check("rst_gcd_resp_rdy", gcd_resp_rdy, 0);
    @(posedge clk); #1 rst = 1'b0;

    // single requester on lane 2
    base_r = resp_lane_log.size();
    pend_q[2].push_back({16'd15, 16'd5});
    wait_idle("t1_idle", 200);
    check("t1_resp_count", resp_lane_log.size() - base_r, 1);
    check_resp("t1_resp", base_r, 2, 16'd5);

    // ptr is now 3: lanes 0 and 3 together must grant 3 first
    base_i = issue_log.size();
    pend_q[0].push_back({16'd9, 16'd6});
    pend_q[3].push_back({16'd8, 16'd4});
    wait_idle("ptr3_idle", 200);
    check_issue("ptr3_first", base_i, 3);
    check_issue("ptr3_second", base_i + 1, 0);
    pend_q[3].push_back({16'd14, 16'd21});
    wait_idle("ptr0_idle", 200);

    // round robin, all lanes continuously valid, ptr starts at 0
    base_i = issue_log.size();
    base_r = resp_lane_log.size();
    for (int k = 0; k < 2; k++) begin
      pend_q[0].push_back({16'd27, 16'd15});
      pend_q[1].push_back({16'd21, 16'd49});
      pend_q[2].push_back({16'd25, 16'd30});
      pend_q[3].push_back({16'd40, 16'd40});
    end
    wait_idle("rr_idle", 500);
    for (int k = 0; k < 8; k++) begin
      check_issue("rr_grant", base_i + k, k % 4);
      check_resp("rr_resp", base_r + k, k % 4, rr_exp[k % 4]);
    end

    // full tag FIFO with all responses backpressured
    rdy_fixed = '0;
    @(negedge clk);
    base_r = resp_lane_log.size();
    for (int k = 0; k < 6; k++) pend_q[1].push_back(full_msg[k]);
    repeat (20) @(negedge clk);
    check("full_inflight", inflight, D);
    check("full_req_rdy", req_rdy, 0);
    check("full_gcd_req_val", gcd_req_val, 0);
    check("full_gcd_resp_rdy", gcd_resp_rdy, 0);
    check("full_no_resp", resp_lane_log.size() - base_r, 0);
    rdy_fixed = '1;
    wait_idle("full_idle", 500);
    for (int k = 0; k < 6; k++) check_resp("full_resp", base_r + k, 1, full_exp[k]);

    // head-of-line backpressure on lane 0
    rdy_fixed = 4'b1110;
    @(negedge clk);
    base_r = resp_lane_log.size();
    pend_q[0].push_back({16'd3, 16'd9});
    repeat (4) @(negedge clk);
    pend_q[1].push_back({16'd250, 16'd190});
    repeat (10) @(negedge clk);
    check("hol_no_resp", resp_lane_log.size() - base_r, 0);
    check("hol_inflight", inflight, 2);
    check("hol_gcd_resp_rdy", gcd_resp_rdy, 0);
    rdy_fixed = '1;
    wait_idle("hol_idle", 300);
    check_resp("hol_first", base_r, 0, 16'd3);
    check_resp("hol_second", base_r + 1, 1, 16'd10);

    // reset mid-operation: three in flight, then reset with new requests pending
    rdy_fixed = '0;
    @(negedge clk);
    pend_q[0].push_back({16'd1, 16'd1});
    pend_q[2].push_back({16'd2, 16'd4});
    pend_q[3].push_back({16'd6, 16'd9});
    n = 0;
    while (inflight != 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_inflight3", inflight, 3);
    @(posedge clk); #3 rst = 1'b1;
    pend_q[1].push_back({16'd5, 16'd250});
    pend_q[0].push_back({16'd8, 16'd12});
    @(negedge clk);
    check("mid_rst_inflight", inflight, 0);
    @(negedge clk);
    check("mid_rst_req_val_driven", req_val, 4'b0011);
    check("mid_rst_req_rdy", req_rdy, 0);
    check("mid_rst_gcd_req_val", gcd_req_val, 0);
    check("mid_rst_resp_val", resp_val, 0);
    check("mid_rst_gcd_resp_rdy", gcd_resp_rdy, 0);
    check("mid_rst_inflight2", inflight, 0);
    base_i = issue_log.size();
    base_r = resp_lane_log.size();
    @(posedge clk); #1 rst = 1'b0;
    rdy_fixed = '1;
    wait_idle("mid_idle", 300);
    check_issue("mid_ptr0_first", base_i, 0);
    check_issue("mid_ptr0_second", base_i + 1, 1);
    check_resp("mid_resp0", base_r, 0, 16'd4);
    check_resp("mid_resp1", base_r + 1, 1, 16'd5);
    check("mid_resp_count", resp_lane_log.size() - base_r, 2);

    // random traffic with random gaps and response backpressure
    max_gap = 3;
    rdy_random = 1'b1;
    base_r = resp_lane_log.size();
    for (int k = 0; k < 200; k++) begin
      ln = int'($urandom_range(0, N - 1));
      pend_q[ln].push_back({16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))});
    end
    wait_idle("rand_idle", 20000);
    check("rand_resp_count", resp_lane_log.size() - base_r, 200);
    max_gap = 0;
    rdy_random = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gcd_unit_arbiter.md
# gcd_unit_arbiter

Shares one `hw_gcd_GcdUnit` among `p_num_reqs` requester streams. Requests are granted round-robin and forwarded to the unit's istream. Each granted requester ID is recorded in an in-order tag FIFO, and the unit's ostream responses are steered back to the requester that issued them. The block sits between the requester-side stream endpoints and a single GCD unit. It adds zero cycles of latency on either path.

## Interface
Parameters:
- `p_num_reqs`, default 4: number of requesters, 2..8.
- `p_tag_depth`, default 4: tag FIFO depth, a power of 2 ≥ 2. This is the maximum number of in-flight transactions.

Ports:
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `req_msg` input, `p_num_reqs`*32 bits: lane i is bits [32i+31:32i], formatted {a[15:0], b[15:0]}.
- `req_val` input, `p_num_reqs` bits: per-requester valid.
- `req_rdy` output, `p_num_reqs` bits: per-requester ready.
- `resp_msg` output, `p_num_reqs`*16 bits: per-requester GCD result.
- `resp_val` output, `p_num_reqs` bits: per-requester response valid.
- `resp_rdy` input, `p_num_reqs` bits: per-requester response ready.
- `gcd_req_msg` output, 32 bits: to the GCD unit istream.
- `gcd_req_val` output, 1 bit: to the GCD unit istream.
- `gcd_req_rdy` input, 1 bit: from the GCD unit istream.
- `gcd_resp_msg` input, 16 bits: from the GCD unit ostream.
- `gcd_resp_val` input, 1 bit: from the GCD unit ostream.
- `gcd_resp_rdy` output, 1 bit: to the GCD unit ostream.
- `inflight` output, clog2(`p_tag_depth`+1) bits: number of occupied tag FIFO entries.

## Operation
- All streams use val/rdy handshakes. A transfer occurs on a cycle where val and rdy are both 1 at the rising edge.
- State:
  - round-robin pointer `ptr`, clog2(`p_num_reqs`) bits;
  - tag FIFO of `p_tag_depth` entries, each clog2(`p_num_reqs`) bits, with read/write pointers and a count.
- Arbitration (combinational):
  - grant `g` = first i with `req_val[i]`=1, scanning i = `ptr`, `ptr`+1, … modulo `p_num_reqs`.
  - If no `req_val` bit is set, there is no grant.
- Request path:
  - `gcd_req_val` = (any `req_val`) & !full.
  - `gcd_req_msg` = `req_msg` lane `g`, or 0 when there is no grant.
  - `req_rdy[i]` = (i == `g`) & `gcd_req_rdy` & !full. All other lanes are 0.
  - Issue fire: `g` is pushed into the tag FIFO and `ptr` ← (`g`+1) mod `p_num_reqs`.
  - `ptr` does not move on cycles without a fire.
  - `req_rdy` is never asserted for a lane whose `req_val` is 0.
- Response path:
  - Let `h` = FIFO head tag.
  - `resp_val[h]` = `gcd_resp_val` & !empty. All other lanes are 0.
  - `resp_msg` lane i = `gcd_resp_msg` for every i (broadcast). Only lane `h` is valid.
  - `gcd_resp_rdy` = !empty & `resp_rdy[h]`.
  - Response fire pops the FIFO.
- Boundary conditions:
  - Full: no issue, even if a pop occurs in the same cycle. Full is evaluated on registered state only.
  - Empty: `gcd_resp_rdy`=0, and a stray `gcd_resp_val` is held off. The GCD unit's ostream stays stalled.
  - Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
  - Pointers wrap modulo `p_tag_depth`.
  - A backpressured head requester (`resp_rdy[h]`=0) stalls all responses. Responses are strictly in issue order.
- Reset, whether asserted asynchronously or mid-transaction:
  - `ptr`=0, FIFO empty, `inflight`=0.
  - While `rst`=1, `req_rdy`, `resp_val`, `gcd_req_val` and `gcd_resp_rdy` are forced to 0.
  - In-flight tags are discarded. The GCD unit is reset on the same `rst`.

## Timing
- Request path, `req_val` → `gcd_req_val` and `gcd_req_rdy` → `req_rdy`: combinational, 0 added cycles.
- Response path, `gcd_resp_val` → `resp_val` and `resp_rdy` → `gcd_resp_rdy`: combinational, 0 added cycles.
- There is no combinational path from the response side to the request side. `full` and `empty` are decoded from registers.
- `inflight` updates on the edge after each push/pop: +1 on push only, −1 on pop only.
- Throughput: one issue and one response per cycle maximum. Overall rate is bounded by GCD unit latency.
- The first request after reset deassertion can issue in the same cycle `rst` falls, provided the handshake is met at the next rising edge.

## Test plan
- **Single requester:** lane 2 sends {15,5}, all other lanes idle → `resp_val[2]` with 5. `ptr`=3 afterwards. No other `resp_val` bit is ever set.
- **Round-robin:** all 4 lanes continuously valid with {27,15}, {21,49}, {25,30}, {40,40} → grant order 0,1,2,3,0,… Responses 3, 7, 5, 40 return on lanes 0–3 in that order.
- **Full FIFO:** `p_tag_depth`=2, GCD ostream held with `gcd_resp_rdy` path blocked via `resp_rdy`=0 → after 2 issues, `inflight`=2 and `req_rdy`=0. Releasing `resp_rdy` pops, then issue resumes. Compare against the sequential gcd model.
- **Head backpressure:** lane 0 sends {3,9}, then lane 1 sends {250,190}. Hold `resp_rdy[0]`=0 for 10 cycles → lane 1 sees no response. `resp_rdy[0]`=1 → lane 0 gets 3, then lane 1 gets 10.
- **Reset mid-operation:** 3 requests in flight, assert `rst` for 1 cycle → `inflight`=0, `ptr`=0, all val/rdy outputs 0 during reset. The post-reset request {5,250} on lane 1 returns 5 on lane 1.
- **Random:** 200 random {a,b} pairs on random lanes, random `resp_rdy`/`req_val` delays of 0–3 cycles → every response matches the gcd reference and arrives on the issuing lane, with per-lane order preserved.
